// File: rtl/gray_a_bn_serie_if.sv
// Handshake bundle for the bit-serial Gray decoder: Gray word in, binary word plus
// adjacency flag out.
interface gray_a_bn_serie_if #(parameter int N = 4);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] G;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] BN;
    logic         out_adj;

    modport master (
        output in_valid, G, out_ready,
        input  in_ready, out_valid, BN, out_adj
    );

    modport slave (
        input  in_valid, G, out_ready,
        output in_ready, out_valid, BN, out_adj
    );
endinterface

// File: rtl/gray_a_bn_serie.sv
// Bit-serial Gray-to-binary decoder: one binary bit per clock, MSB first, plus a
// flag telling whether the accepted word is a single-bit step from the previous one.
module gray_a_bn_serie #(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_a_bn_serie_if.slave      bus,
    output logic                  busy
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  g_q, g_d;
    logic [N-1:0]  bn_q, bn_d;
    logic [KW-1:0] k_q, k_d;
    logic [N-1:0]  prev_g_q, prev_g_d;
    logic          prev_v_q, prev_v_d;
    logic          adj_q, adj_d;
    logic [N-1:0]  bn_sh;

    // BN is cleared on acceptance, so the shifted copy supplies BN[k+1] and a 0 above the MSB.
    assign bn_sh = bn_q >> 1;

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        bn_d     = bn_q;
        k_d      = k_q;
        prev_g_d = prev_g_q;
        prev_v_d = prev_v_q;
        adj_d    = adj_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    g_d      = bus.G;
                    bn_d     = '0;
                    k_d      = KW'(N - 1);
                    adj_d    = prev_v_q && ($countones(bus.G ^ prev_g_q) == 1);
                    prev_g_d = bus.G;
                    prev_v_d = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                bn_d[k_q] = g_q[k_q] ^ bn_sh[k_q];
                if (k_q == '0) state_d = DONE;
                else           k_d = k_q - 1'b1;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            g_q      <= '0;
            bn_q     <= '0;
            k_q      <= '0;
            prev_g_q <= '0;
            prev_v_q <= 1'b0;
            adj_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            bn_q     <= bn_d;
            k_q      <= k_d;
            prev_g_q <= prev_g_d;
            prev_v_q <= prev_v_d;
            adj_q    <= adj_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.BN        = bn_q;
    assign bus.out_adj   = adj_q;
    assign busy          = (state_q == DECODE);
endmodule

// File: tb/tb_gray_a_bn_serie.sv
// Directed bench for gray_a_bn_serie: a 4-bit and an 8-bit instance driven from
// vector tables and hand-written backpressure/reset sequences.
module tb_gray_a_bn_serie;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_a_bn_serie_if #(.N(4)) b4();
    gray_a_bn_serie_if #(.N(8)) b8();
    logic busy4, busy8;

    gray_a_bn_serie #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave), .busy(busy4));
    gray_a_bn_serie #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave), .busy(busy8));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ir;
        logic       ov;
        logic       bz;
        logic       adj;
        logic [7:0] bn;
    } st_t;

    typedef struct {
        logic [3:0] g;
        logic [3:0] bn;
        logic       adj;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic st_t st(input bit w);
        st_t s;
        if (w) s = '{ir: b8.in_ready, ov: b8.out_valid, bz: busy8, adj: b8.out_adj, bn: b8.BN};
        else   s = '{ir: b4.in_ready, ov: b4.out_valid, bz: busy4, adj: b4.out_adj, bn: {4'b0, b4.BN}};
        return s;
    endfunction

    task automatic drive(input bit w, input logic [7:0] g, input logic v);
        if (w) begin b8.G = g; b8.in_valid = v; end
        else begin b4.G = g[3:0]; b4.in_valid = v; end
    endtask

    task automatic set_oready(input bit w, input logic r);
        if (w) b8.out_ready = r;
        else   b4.out_ready = r;
    endtask

    // Caller is at a negedge in IDLE; returns at the negedge where out_valid is first seen.
    task automatic send(input bit w, input logic [7:0] g, input logic [7:0] exp_bn,
                        input logic exp_adj, input string nm, output int acc);
        int n = w ? 8 : 4;
        int cnt = 0;
        int bz = 0;
        st_t s;
        s = st(w);
        chk({nm, " in_ready"}, 32'(s.ir), 32'd1);
        drive(w, g, 1'b1);
        @(negedge clk);
        acc = cyc;
        drive(w, g, 1'b0);
        s = st(w);
        while (!s.ov && cnt < 40) begin
            if (s.bz) bz++;
            @(negedge clk);
            cnt++;
            s = st(w);
        end
        chk({nm, " latency"}, 32'(cnt), 32'(n));
        chk({nm, " busy cycles"}, 32'(bz), 32'(n));
        chk({nm, " BN"}, 32'(s.bn), 32'(exp_bn));
        chk({nm, " out_adj"}, 32'(s.adj), 32'(exp_adj));
    endtask

    task automatic pop(input bit w, input string nm);
        st_t s;
        set_oready(w, 1'b1);
        @(negedge clk);
        set_oready(w, 1'b0);
        s = st(w);
        chk({nm, " pop in_ready"}, 32'(s.ir), 32'd1);
        chk({nm, " pop out_valid"}, 32'(s.ov), 32'd0);
    endtask

    initial begin
        vec_t adjv[8];
        st_t  s;
        int   acc, prev_acc;
        logic [3:0] gv;

        adjv[0] = '{g: 4'b0000, bn: 4'b0000, adj: 1'b0};
        adjv[1] = '{g: 4'b0001, bn: 4'b0001, adj: 1'b1};
        adjv[2] = '{g: 4'b0011, bn: 4'b0010, adj: 1'b1};
        adjv[3] = '{g: 4'b0010, bn: 4'b0011, adj: 1'b1};
        adjv[4] = '{g: 4'b0101, bn: 4'b0110, adj: 1'b0};
        adjv[5] = '{g: 4'b0101, bn: 4'b0110, adj: 1'b0};
        adjv[6] = '{g: 4'b1000, bn: 4'b1111, adj: 1'b0};
        adjv[7] = '{g: 4'b0000, bn: 4'b0000, adj: 1'b1};

        drive(1'b0, 8'h0, 1'b0);
        drive(1'b1, 8'h0, 1'b0);
        set_oready(1'b0, 1'b0);
        set_oready(1'b1, 1'b0);

        #1;
        s = st(1'b0);
        chk("reset in_ready", 32'(s.ir), 32'd1);
        chk("reset out_valid", 32'(s.ov), 32'd0);
        chk("reset busy", 32'(s.bz), 32'd0);
        chk("reset BN", 32'(s.bn), 32'd0);
        chk("reset out_adj", 32'(s.adj), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(1'b0, {4'b0, adjv[i].g}, {4'b0, adjv[i].bn}, adjv[i].adj, $sformatf("adj[%0d]", i), acc);
            pop(1'b0, $sformatf("adj[%0d]", i));
        end

        send(1'b0, 8'h02, 8'h03, 1'b1, "g0010", acc);
        pop(1'b0, "g0010");

        prev_acc = 0;
        for (int v = 0; v < 16; v++) begin
            gv = 4'(v ^ (v >> 1));
            send(1'b0, {4'b0, gv}, 8'(v), 1'b1, $sformatf("sweep[%0d]", v), acc);
            if (v > 0) chk($sformatf("sweep[%0d] spacing", v), 32'(acc - prev_acc), 32'd6);
            prev_acc = acc;
            if (v < 15) pop(1'b0, $sformatf("sweep[%0d]", v));
        end
        pop(1'b0, "sweep[15]");

        send(1'b0, 8'h08, 8'h0F, 1'b0, "bp g1000", acc);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'($urandom_range(15)), (i % 2 == 0));
            @(negedge clk);
            s = st(1'b0);
            chk($sformatf("bp[%0d] BN", i), 32'(s.bn), 32'h0F);
            chk($sformatf("bp[%0d] out_valid", i), 32'(s.ov), 32'd1);
            chk($sformatf("bp[%0d] in_ready", i), 32'(s.ir), 32'd0);
        end
        drive(1'b0, 8'h0, 1'b0);
        pop(1'b0, "bp");
        send(1'b0, 8'h09, 8'h0E, 1'b1, "after bp g1001", acc);
        pop(1'b0, "after bp");

        drive(1'b0, 8'h0F, 1'b1);
        @(negedge clk);
        drive(1'b0, 8'h0, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        s = st(1'b0);
        chk("midrst out_valid", 32'(s.ov), 32'd0);
        chk("midrst busy", 32'(s.bz), 32'd0);
        chk("midrst BN", 32'(s.bn), 32'd0);
        chk("midrst in_ready", 32'(s.ir), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 8'h01, 8'h01, 1'b0, "post-rst g0001", acc);
        pop(1'b0, "post-rst");

        send(1'b1, 8'hFF, 8'hAA, 1'b0, "n8 gFF", acc);
        pop(1'b1, "n8 gFF");
        send(1'b1, 8'h80, 8'hFF, 1'b0, "n8 g80", acc);
        pop(1'b1, "n8 g80");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
